// File: rtl/pcram_loader.sv
// Program RAM with a streaming loader: words are written from address 0 until in_last or
// the array fills, then the PC free-runs over the image. Optional PCRAM_CHECKSUM_EN adds a checksum output.
module pcram_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          CLRn,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          pc_clr,
  output logic [AW-1:0] PC,
  output logic [31:0]   DataOut,
  output logic          running,
  output logic [AW:0]   word_count,
  output logic          overflow
`ifdef PCRAM_CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q, wa_q;
  logic [AW:0]   wc_q;
  logic [31:0]   dout_q;
  logic          ready_q, run_q, ovf_q;
  logic [31:0]   mem_q [DEPTH];

  logic xfer, last_slot, pc_wrap;

  // in_ready is only ever high in LOAD, so it alone qualifies a transfer
  assign xfer      = in_valid && ready_q;
  assign last_slot = (wa_q == AW'(DEPTH - 1));
  assign pc_wrap   = ({1'b0, pc_q} == (wc_q - 1'b1));

  assign in_ready   = ready_q;
  assign running    = run_q;
  assign PC         = pc_q;
  assign DataOut    = dout_q;
  assign word_count = wc_q;
  assign overflow   = ovf_q;

`ifdef PCRAM_CHECKSUM_EN
  logic [31:0] csum_q;
  assign checksum = csum_q;

  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn) begin
      csum_q <= '0;
    end else if ((state_q == S_IDLE && load_start) || (state_q == S_RUN && load_start)) begin
      csum_q <= '0;
    end else if (state_q == S_LOAD && xfer) begin
      csum_q <= csum_q + in_data;
    end
  end
`endif

  // Array is deliberately left out of reset so images survive CLRn
  always_ff @(posedge clk) begin
    if (xfer) mem_q[wa_q] <= in_data;
  end

  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wa_q    <= '0;
      wc_q    <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
            wa_q    <= '0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            wa_q <= wa_q + 1'b1;
            wc_q <= wc_q + 1'b1;
            // Filling the last slot without in_last means the image did not fit
            if (in_last || last_slot) begin
              state_q <= S_RUN;
              ready_q <= 1'b0;
              run_q   <= 1'b1;
              pc_q    <= '0;
              ovf_q   <= !in_last;
            end
          end
        end
        S_RUN: begin
          dout_q <= mem_q[pc_q];
          if (load_start) begin
            state_q <= S_LOAD;
            run_q   <= 1'b0;
            ready_q <= 1'b1;
            pc_q    <= '0;
            wa_q    <= '0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
          end else if (pc_clr || pc_wrap) begin
            pc_q <= '0;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
